rf_wport_arb: RTL
=================

Name: rf_wport_arb

Overview:
- Shares the single register-file write port between the in-order pipeline writeback (WB) stage and a multi-cycle unit (MCU: divider or late load) that returns results out of band.
- Holds MCU results in a small FIFO until the write port is free.
- Keeps a 32-entry pending-destination scoreboard and raises a hazard stall so decode never reads or overwrites a register whose MCU result has not yet been written.
- Sits between WB/MCU and the RF write inputs (we, wR, write data).

Parameters:
- DEPTH, 2, MCU result FIFO entries (power of two, >=2).
- STARVE_MAX, 4, consecutive cycles a non-empty FIFO may be denied before a WB bubble is requested.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pipe_we  in  1  WB stage write request
- pipe_wr  in  5  WB destination register
- pipe_wd  in  32  WB write data
- mc_issue  in  1  MCU operation accepted this cycle
- mc_issue_rd  in  5  destination of issued MCU op
- mc_done_valid  in  1  MCU result valid
- mc_done_rd  in  5  MCU result destination
- mc_done_data  in  32  MCU result data
- mc_done_ready  out  1  FIFO can accept (= !full)
- id_rs1  in  5  decode source 1
- id_rs2  in  5  decode source 2
- id_rd  in  5  decode destination
- hazard_stall  out  1  decode must stall
- starve_stall  out  1  upstream must present pipe_we=0 next cycle
- rf_we  out  1  RF write enable
- rf_wr  out  5  RF write address
- rf_wd  out  32  RF write data
- grant_mc  out  1  current RF write comes from the FIFO

Behaviour:
- Reset: FIFO empty, pending=0, starve counter=0; rf_we=0, grant_mc=0, starve_stall=0, hazard_stall=0, mc_done_ready=0 while rst high; rf_wr/rf_wd=0.
- Port free: pipe_we==0 or pipe_wr==0.
- Arbitration (combinational, same cycle):
  - WB has absolute priority: if pipe_we && pipe_wr!=0, then rf_we=1, rf_wr/rf_wd=pipe_wr/pipe_wd, grant_mc=0.
  - Else if FIFO non-empty: the head drives the port; grant_mc=1, rf_we=(head_rd!=0), and the head pops at the clock edge.
  - Else rf_we=0.
- FIFO:
  - Pushes when mc_done_valid && mc_done_ready.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Push when full is impossible because ready is low.
  - Pointers wrap modulo DEPTH.
- Scoreboard:
  - pending[mc_issue_rd] is set on mc_issue when rd!=0.
  - pending[head_rd] clears when the head pops.
  - Set and clear of the same index in one cycle: set wins.
  - pending[0] is always 0.
- hazard_stall (combinational) = pending[id_rs1] | pending[id_rs2] | pending[id_rd], with index 0 ignored. This also blocks a WAW where WB would overwrite a pending register.
- Starvation:
  - Counter increments each cycle the FIFO is non-empty and WB holds the port.
  - Counter clears on any pop or when the FIFO is empty.
  - starve_stall is registered: it goes high the cycle after the count reaches STARVE_MAX, and stays high until the next pop.
- Reset mid-operation discards all FIFO contents and pending bits immediately.

Optional Feature:
- RF_ARB_BYPASS_EN defined:
  - When the FIFO is empty, mc_done_valid=1 and the port is free, the MCU result writes the RF in the same cycle (grant_mc=1) and is not enqueued.
  - Its pending bit clears at that edge.
- Not defined: every MCU result passes through the FIFO, so minimum done-to-write latency is 1 cycle.

Test Plan:
- Reset then idle: rf_we=0, hazard_stall=0, mc_done_ready=1 after rst falls.
- mc_issue rd=5, then id_rs1=5: hazard_stall=1; mc_done rd=5 data=0xDEADBEEF with pipe_we=0; next cycle rf_we=1, rf_wr=5, rf_wd=0xDEADBEEF, grant_mc=1; hazard_stall=0 the cycle after. With RF_ARB_BYPASS_EN, the write happens in the done cycle.
- Collision: mc_done rd=7 while pipe_we=1 wr=3 for 3 cycles: RF writes reg 3 each cycle; reg 7 is written on the first cycle with pipe_we=0; no data lost.
- Starvation: FIFO non-empty with pipe_we=1 wr=9 continuously and STARVE_MAX=4: starve_stall rises after 4 denied cycles; bench drops pipe_we; FIFO pops; starve_stall falls.
- Full: two results pushed with the port busy (DEPTH=2): mc_done_ready=0; a third mc_done_valid is held; after one pop, ready=1 and it is accepted; writes occur in order.
- rd=0: mc_issue rd=0 sets no pending bit; its result pops with rf_we=0. Async rst asserted with 2 FIFO entries: empty and pending cleared immediately, rf_we=0.

Source files
------------

// File: rtl/rf_wport_arb_if.sv
// ---------------------------------------------------------------------------
// rf_wport_arb_if
//
// Bundles every signal of the register-file write-port arbiter except clk and
// rst. The signal names match the arbiter's documented port list.
//
//   master : the surrounding pipeline / testbench. It drives the WB request,
//            MCU issue/done and decode operands, and observes the results.
//   slave  : the arbiter itself.
//
// Signal summary
//   pipe_we/pipe_wr/pipe_wd           WB stage write request, dest, data
//   mc_issue/mc_issue_rd              MCU op accepted this cycle, its dest
//   mc_done_valid/_rd/_data           MCU result offered to the arbiter
//   mc_done_ready                     arbiter can take the MCU result
//   id_rs1/id_rs2/id_rd               decode-stage register operands
//   hazard_stall                      decode must stall
//   starve_stall                      upstream must present pipe_we=0 next cycle
//   rf_we/rf_wr/rf_wd                 register-file write port
//   grant_mc                          current RF write comes from the MCU side
//
// Handshake (mc_done_*): a result transfers on every rising clk edge where
// mc_done_valid and mc_done_ready are both high. While valid is high and
// ready is low the producer holds rd/data stable; ready never depends on
// valid.
// ---------------------------------------------------------------------------
interface rf_wport_arb_if;
    logic        pipe_we;
    logic [4:0]  pipe_wr;
    logic [31:0] pipe_wd;
    logic        mc_issue;
    logic [4:0]  mc_issue_rd;
    logic        mc_done_valid;
    logic [4:0]  mc_done_rd;
    logic [31:0] mc_done_data;
    logic        mc_done_ready;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        hazard_stall;
    logic        starve_stall;
    logic        rf_we;
    logic [4:0]  rf_wr;
    logic [31:0] rf_wd;
    logic        grant_mc;

    modport master (
        output pipe_we, pipe_wr, pipe_wd,
        output mc_issue, mc_issue_rd,
        output mc_done_valid, mc_done_rd, mc_done_data,
        input  mc_done_ready,
        output id_rs1, id_rs2, id_rd,
        input  hazard_stall, starve_stall,
        input  rf_we, rf_wr, rf_wd, grant_mc
    );

    modport slave (
        input  pipe_we, pipe_wr, pipe_wd,
        input  mc_issue, mc_issue_rd,
        input  mc_done_valid, mc_done_rd, mc_done_data,
        output mc_done_ready,
        input  id_rs1, id_rs2, id_rd,
        output hazard_stall, starve_stall,
        output rf_we, rf_wr, rf_wd, grant_mc
    );
endinterface

// File: rtl/rf_wport_arb.sv
// ---------------------------------------------------------------------------
// rf_wport_arb
//
// Shares the single register-file write port between the in-order WB stage
// and a multi-cycle unit (divider / late load) that returns results out of
// band. MCU results wait in a small FIFO until the port is free; a 32-entry
// pending-destination scoreboard makes decode stall on any register whose
// MCU result has not been written yet (covers RAW and WAW).
//
// Ports
//   clk   clock
//   rst   asynchronous, active-high reset
//   bus   rf_wport_arb_if.slave -- WB request, MCU issue/done, decode
//         operands, hazard/starvation stalls and the RF write port
//
// Parameters
//   DEPTH       MCU result FIFO entries (power of two, >= 2)
//   STARVE_MAX  consecutive cycles a non-empty FIFO may be denied the port
//               before a WB bubble is requested
//
// Build option
//   RF_ARB_BYPASS_EN  when defined, an MCU result arriving while the FIFO is
//                     empty and the port is free writes the RF in the same
//                     cycle instead of being enqueued.
//
// Arbitration: WB wins whenever it really writes (pipe_we && pipe_wr != 0).
// Otherwise the FIFO head owns the port and pops at the clock edge; a head
// with rd == 0 still pops but with rf_we low.
// ---------------------------------------------------------------------------
module rf_wport_arb #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    rf_wport_arb_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [4:0]    fifo_rd_q   [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [31:0]   pending_q, pending_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          starve_stall_q, starve_stall_d;

    // -----------------------------------------------------------------------
    // Decode of the current cycle
    // -----------------------------------------------------------------------
    logic        fifo_empty;
    logic        fifo_full;
    logic        wb_take;
    logic        pop;
    logic        push;
    logic        bypass;
    logic [4:0]  head_rd;
    logic [31:0] head_data;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);
    assign head_rd    = fifo_rd_q[rd_ptr_q];
    assign head_data  = fifo_data_q[rd_ptr_q];

    // A WB write to x0 is not a real write, so it leaves the port free.
    assign wb_take = bus.pipe_we && (bus.pipe_wr != 5'd0);

`ifdef RF_ARB_BYPASS_EN
    // Only when nothing older is queued, so result order is preserved.
    assign bypass = !rst && fifo_empty && bus.mc_done_valid && !wb_take;
`else
    assign bypass = 1'b0;
`endif

    assign pop  = !rst && !wb_take && !fifo_empty;
    // Ready is driven low in reset, so no transfer can happen then.
    assign push = bus.mc_done_valid && bus.mc_done_ready && !bypass;

    // -----------------------------------------------------------------------
    // Write-port mux and handshake outputs
    // -----------------------------------------------------------------------
    always_comb begin
        bus.rf_we         = 1'b0;
        bus.rf_wr         = 5'd0;
        bus.rf_wd         = 32'd0;
        bus.grant_mc      = 1'b0;
        bus.mc_done_ready = !rst && !fifo_full;

        if (!rst) begin
            if (wb_take) begin
                bus.rf_we = 1'b1;
                bus.rf_wr = bus.pipe_wr;
                bus.rf_wd = bus.pipe_wd;
            end else if (!fifo_empty) begin
                bus.grant_mc = 1'b1;
                bus.rf_we    = (head_rd != 5'd0);
                bus.rf_wr    = head_rd;
                bus.rf_wd    = head_data;
            end else if (bypass) begin
                bus.grant_mc = 1'b1;
                bus.rf_we    = (bus.mc_done_rd != 5'd0);
                bus.rf_wr    = bus.mc_done_rd;
                bus.rf_wd    = bus.mc_done_data;
            end
        end
    end

    // -----------------------------------------------------------------------
    // FIFO pointers and occupancy
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // DEPTH is a power of two, so natural pointer overflow is the wrap.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Entry storage is not reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= bus.mc_done_rd;
            fifo_data_q[wr_ptr_q] <= bus.mc_done_data;
        end
    end

    // -----------------------------------------------------------------------
    // Pending-destination scoreboard
    // -----------------------------------------------------------------------
    always_comb begin
        pending_d = pending_q;

        if (pop) begin
            pending_d[head_rd] = 1'b0;
        end
        if (bypass) begin
            pending_d[bus.mc_done_rd] = 1'b0;
        end
        // Applied last so a new issue to the register being retired this
        // cycle stays pending.
        if (bus.mc_issue && (bus.mc_issue_rd != 5'd0)) begin
            pending_d[bus.mc_issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // x0 is never pending, so the index-0 guard is belt and braces.
    always_comb begin
        bus.hazard_stall = 1'b0;
        if (!rst) begin
            bus.hazard_stall =
                ((bus.id_rs1 != 5'd0) && pending_q[bus.id_rs1]) ||
                ((bus.id_rs2 != 5'd0) && pending_q[bus.id_rs2]) ||
                ((bus.id_rd  != 5'd0) && pending_q[bus.id_rd]);
        end
    end

    // -----------------------------------------------------------------------
    // Starvation guard
    //
    // The counter measures consecutive cycles in which a queued result was
    // denied the port by WB. The edge at which it reaches STARVE_MAX also
    // sets starve_stall, so the request is visible in the cycle right after
    // the STARVE_MAX-th denial. The stall holds until the FIFO finally pops.
    // -----------------------------------------------------------------------
    always_comb begin
        starve_cnt_d   = starve_cnt_q;
        starve_stall_d = starve_stall_q;

        if (pop || fifo_empty) begin
            starve_cnt_d = '0;
        end else if (wb_take && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + STARVE_ONE;
        end

        if (pop) begin
            starve_stall_d = 1'b0;
        end else if (starve_cnt_d == STARVE_LIM) begin
            starve_stall_d = 1'b1;
        end
    end

    assign bus.starve_stall = starve_stall_q;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            pending_q      <= '0;
            starve_cnt_q   <= '0;
            starve_stall_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            pending_q      <= pending_d;
            starve_cnt_q   <= starve_cnt_d;
            starve_stall_q <= starve_stall_d;
        end
    end

endmodule
